// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory-access stage; byte/half/word loads and stores over a req/ack bus,
// with misalignment detection, bus timeout and a single registered write-back result.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [7:0] OP_LB = 8'b11100000, OP_LH = 8'b11100001, OP_LW = 8'b11100011;
    localparam logic [7:0] OP_LBU = 8'b11100100, OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_SB = 8'b11101000, OP_SH = 8'b11101001, OP_SW = 8'b11101011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [1:0]  off_q, off_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, bwdata_q, bwdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        valid_q, valid_d, mis_q, mis_d, err_q, err_d, owreg_q, owreg_d;
    logic [4:0]  owd_q, owd_d;
    logic [31:0] owdata_q, owdata_d;

    logic        is_ld, is_st, is_mem, misal, accept, timeout;
    logic [1:0]  sz;
    logic [31:0] sh, ld;

    always_comb begin
        is_ld   = aluop_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_st   = aluop_i inside {OP_SB, OP_SH, OP_SW};
        is_mem  = is_ld | is_st;
        sz      = aluop_i[1:0];
        misal   = (sz == 2'b01 & mem_addr_i[0]) | (sz == 2'b11 & |mem_addr_i[1:0]);
        accept  = state_q == IDLE & valid_i & is_mem & ~misal;
        timeout = state_q == BUSY & ~bus_ack_i & cnt_q == 8'(TIMEOUT_CYCLES - 1);
        stall_o = accept | (state_q == BUSY & ~bus_ack_i & ~timeout);
        // Loaded lane is shifted down to bit 0, then sign/zero-extended by op size and op[2].
        sh      = bus_rdata_i >> {off_q, 3'b000};
        ld      = op_q[1:0] == 2'b00 ? {{24{~op_q[2] & sh[7]}}, sh[7:0]} :
                  op_q[1:0] == 2'b01 ? {{16{~op_q[2] & sh[15]}}, sh[15:0]} : bus_rdata_i;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        off_d    = off_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        bwdata_d = bwdata_q;
        valid_d  = 1'b0;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        owd_d    = owd_q;
        owreg_d  = owreg_q;
        owdata_d = owdata_q;
        if (state_q == IDLE) begin
            cnt_d = 8'd0;
            if (valid_i & ~is_mem) begin
                valid_d  = 1'b1;
                owd_d    = wd_i;
                owreg_d  = wreg_i;
                owdata_d = wdata_i;
            end else if (valid_i & misal) begin
                valid_d  = 1'b1;
                mis_d    = 1'b1;
                owd_d    = wd_i;
                owreg_d  = 1'b0;
                owdata_d = 32'd0;
            end else if (accept) begin
                state_d  = BUSY;
                op_d     = aluop_i[3:0];
                wd_d     = wd_i;
                wreg_d   = wreg_i;
                off_d    = mem_addr_i[1:0];
                req_d    = 1'b1;
                we_d     = is_st;
                addr_d   = {mem_addr_i[31:2], 2'b00};
                sel_d    = sz == 2'b00 ? 4'b0001 << mem_addr_i[1:0] :
                           sz == 2'b01 ? 4'b0011 << mem_addr_i[1:0] : 4'b1111;
                bwdata_d = sz == 2'b00 ? {4{reg2_i[7:0]}} :
                           sz == 2'b01 ? {2{reg2_i[15:0]}} : reg2_i;
            end
        end else if (bus_ack_i) begin
            state_d  = IDLE;
            req_d    = 1'b0;
            valid_d  = 1'b1;
            owd_d    = wd_q;
            owreg_d  = ~op_q[3] & wreg_q;
            owdata_d = op_q[3] ? 32'd0 : ld;
        end else if (timeout) begin
            state_d  = IDLE;
            req_d    = 1'b0;
            valid_d  = 1'b1;
            err_d    = 1'b1;
            owd_d    = wd_q;
            owreg_d  = 1'b0;
            owdata_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            op_q     <= 4'd0;
            wd_q     <= 5'd0;
            wreg_q   <= 1'b0;
            off_q    <= 2'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            sel_q    <= 4'd0;
            bwdata_q <= 32'd0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            owd_q    <= 5'd0;
            owreg_q  <= 1'b0;
            owdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            off_q    <= off_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            bwdata_q <= bwdata_d;
            valid_q  <= valid_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
            owd_q    <= owd_d;
            owreg_q  <= owreg_d;
            owdata_q <= owdata_d;
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = bwdata_q;
    assign valid_o     = valid_q;
    assign wd_o        = owd_q;
    assign wreg_o      = owreg_q;
    assign wdata_o     = owdata_q;
    assign misalign_o  = mis_q;
    assign bus_err_o   = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage; expected write-back results are
// queued when an op is driven and compared when valid_o pulses.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TO = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 1'b0, wreg_i = 1'b0, bus_ack_i = 1'b0;
    logic [7:0]  aluop_i = 8'd0;
    logic [4:0]  wd_i = 5'd0;
    logic [31:0] wdata_i = 32'd0, mem_addr_i = 32'd0, reg2_i = 32'd0, bus_rdata_i = 32'd0;
    logic        stall_o, bus_req_o, bus_we_o, valid_o, wreg_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wd_i(wd_i),
        .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'(valid_o), 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("wd_o", 32'(wd_o), 32'(e.wd));
                chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
                chk("wdata_o", wdata_o, e.wdata);
                chk("misalign_o", 32'(misalign_o), 32'(e.mis));
                chk("bus_err_o", 32'(bus_err_o), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    endtask

    // Single-cycle ops: non-memory or misaligned memory access.
    task automatic quick_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                            input logic [4:0] wd, input logic [31:0] wdata, input exp_t e);
        drive(op, addr, 32'h0, wd, 1'b1, wdata);
        sb.push_back(e);
        #1;
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk({tag, "_no_req"}, 32'(bus_req_o), 32'd0);
    endtask

    // Aligned memory op; ack_cyc is the cycle offset (from acceptance) of the ack, 0 = never.
    task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input int ack_cyc,
                          input logic [31:0] rdata, input logic ewe, input logic [3:0] esel,
                          input logic [31:0] ebw, input int ereq, input exp_t e);
        int  stalls = 0, reqs = 0;
        bit  done = 1'b0;
        drive(op, addr, reg2, wd, 1'b1, 32'h0BAD_0BAD);
        sb.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 1) begin
                valid_i = 1'b0;
                chk({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
                chk({tag, "_sel"}, 32'(bus_sel_o), 32'(esel));
                chk({tag, "_we"}, 32'(bus_we_o), 32'(ewe));
                if (ewe) chk({tag, "_bwdata"}, bus_wdata_o, ebw);
            end
            bus_ack_i   = (c == ack_cyc && c > 0);
            bus_rdata_i = bus_ack_i ? rdata : 32'h5A5A_A5A5;
            #1;
            if (c > 0 && !bus_req_o) done = 1'b1;
            else begin
                stalls += int'(stall_o);
                reqs   += int'(bus_req_o);
                tick();
            end
        end
        bus_ack_i = 1'b0;
        chk({tag, "_bound"}, 32'(done), 32'd1);
        chk({tag, "_req_cycles"}, 32'(reqs), 32'(ereq));
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(ereq));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_fields", {bus_addr_o[15:0], bus_wdata_o[7:0], 4'(bus_sel_o), 4'(wd_o)}, 32'd0);
        chk("rst_wdata", wdata_o | bus_wdata_o | bus_addr_o, 32'd0);
        chk("rst_flags", {28'd0, wreg_o, misalign_o, bus_err_o, bus_we_o}, 32'd0);
        rst = 1'b0;
        tick();

        quick_op("add", 8'b00100000, 32'h0, 5'd5, 32'h0000_1234, '{5'd5, 1'b1, 32'h0000_1234, 1'b0, 1'b0});
        quick_op("nonmem_e2", 8'b11100010, 32'h3, 5'd9, 32'hA5A5_0001, '{5'd9, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0});
        mem_op("lb", 8'b11100000, 32'h103, 32'h1122_3344, 5'd7, 3, 32'h80FF_0000, 1'b0, 4'b1000,
               32'h0, 3, '{5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0});
        mem_op("lbu", 8'b11100100, 32'h103, 32'h0, 5'd8, 3, 32'h80FF_0000, 1'b0, 4'b1000,
               32'h0, 3, '{5'd8, 1'b1, 32'h0000_0080, 1'b0, 1'b0});
        mem_op("sh", 8'b11101001, 32'h202, 32'hDEAD_BEEF, 5'd3, 1, 32'h0, 1'b1, 4'b1100,
               32'hBEEF_BEEF, 1, '{5'd3, 1'b0, 32'h0, 1'b0, 1'b0});
        mem_op("lh", 8'b11100001, 32'h102, 32'h0, 5'd10, 2, 32'h8001_1234, 1'b0, 4'b1100,
               32'h0, 2, '{5'd10, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0});
        mem_op("lhu", 8'b11100101, 32'h100, 32'h0, 5'd11, 2, 32'h8001_9234, 1'b0, 4'b0011,
               32'h0, 2, '{5'd11, 1'b1, 32'h0000_9234, 1'b0, 1'b0});
        mem_op("lw", 8'b11100011, 32'h10, 32'h0, 5'd12, 1, 32'hCAFE_F00D, 1'b0, 4'b1111,
               32'h0, 1, '{5'd12, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0});
        mem_op("sw", 8'b11101011, 32'h20, 32'h1234_5678, 5'd13, 2, 32'h0, 1'b1, 4'b1111,
               32'h1234_5678, 2, '{5'd13, 1'b0, 32'h0, 1'b0, 1'b0});
        mem_op("sb", 8'b11101000, 32'h1, 32'h0000_00AB, 5'd14, 1, 32'h0, 1'b1, 4'b0010,
               32'hABAB_ABAB, 1, '{5'd14, 1'b0, 32'h0, 1'b0, 1'b0});
        quick_op("mis_lw", 8'b11100011, 32'h6, 5'd15, 32'h0, '{5'd15, 1'b0, 32'h0, 1'b1, 1'b0});
        quick_op("mis_lh", 8'b11100001, 32'h101, 5'd16, 32'h0, '{5'd16, 1'b0, 32'h0, 1'b1, 1'b0});
        quick_op("mis_sw", 8'b11101011, 32'h2, 5'd17, 32'h0, '{5'd17, 1'b0, 32'h0, 1'b1, 1'b0});
        mem_op("lw_to", 8'b11100011, 32'h40, 32'h0, 5'd18, 0, 32'h0, 1'b0, 4'b1111,
               32'h0, TO, '{5'd18, 1'b0, 32'h0, 1'b0, 1'b1});
        mem_op("lw_ack16", 8'b11100011, 32'h44, 32'h0, 5'd19, TO, 32'h0BEE_F123, 1'b0, 4'b1111,
               32'h0, TO, '{5'd19, 1'b1, 32'h0BEE_F123, 1'b0, 1'b0});
        tick();

        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("idle_ack_ignored", 32'(bus_req_o | valid_o), 32'd0);

        drive(8'b11100011, 32'h300, 32'h0, 5'd20, 1'b1, 32'h0);
        tick();
        valid_i = 1'b0;
        chk("mid_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        chk("mid_rst_req", 32'(bus_req_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_fields", bus_addr_o | {27'd0, wd_o} | {28'd0, bus_sel_o}, 32'd0);
        tick();
        bus_ack_i = 1'b0;
        chk("late_ack_valid", 32'(valid_o | bus_req_o), 32'd0);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
